// File: rtl/cal_pkg.sv
// Shared definitions for the BCD calendar counter: month constants, BCD
// helpers, month-length lookup, scan digit indices and the load FSM states.
package cal_pkg;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  // seg7_sel values: 0 is the leftmost digit (year tens)
  localparam logic [2:0] SEL_YY_TENS = 3'd0;
  localparam logic [2:0] SEL_YY_ONES = 3'd1;
  localparam logic [2:0] SEL_MM_TENS = 3'd2;
  localparam logic [2:0] SEL_MM_ONES = 3'd3;
  localparam logic [2:0] SEL_DD_TENS = 3'd4;
  localparam logic [2:0] SEL_DD_ONES = 3'd5;

  typedef enum logic {ST_RUN, ST_CHECK} cal_state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : {v[7:4], v[3:0] - 4'h1};
  endfunction

  // yy%4==0 decided on the digits: tens parity selects which ones digits qualify
  function automatic logic is_leap(input logic [7:0] yy);
    logic [3:0] ones;
    ones = yy[3:0];
    if (!yy[4]) return (ones == 4'h0) || (ones == 4'h4) || (ones == 4'h8);
    else        return (ones == 4'h2) || (ones == 4'h6);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] yy, input logic [7:0] mm);
    case (mm)
      MON_FEB:                            return is_leap(yy) ? 8'h29 : 8'h28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: return 8'h30;
      default:                            return 8'h31;
    endcase
  endfunction

  // January looks back to December of the previous year, which is always 31
  function automatic logic [7:0] prev_month_len(input logic [7:0] yy, input logic [7:0] mm);
    if (mm == MON_JAN) return 8'h31;
    else               return month_len(yy, bcd_dec(mm));
  endfunction

endpackage

// File: rtl/bcd_calendar_counter_if.sv
// Control, load and display bundle of the calendar counter.
// The down input exists only when CAL_DOWN_EN is defined.
interface bcd_calendar_counter_if;
  logic       enable;
`ifdef CAL_DOWN_EN
  logic       down;
`endif
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_yy, load_mm, load_dd;
  logic       load_err;
  logic [7:0] yy, mm, dd;
  logic       wrap;
  logic       at_end;
  logic [2:0] seg7_sel;
  logic [3:0] digit;
  logic       dpt;

  modport master (
`ifdef CAL_DOWN_EN
    output down,
`endif
    output enable, load_valid, load_yy, load_mm, load_dd,
    input  load_ready, load_err, yy, mm, dd, wrap, at_end, seg7_sel, digit, dpt
  );

  modport slave (
`ifdef CAL_DOWN_EN
    input  down,
`endif
    input  enable, load_valid, load_yy, load_mm, load_dd,
    output load_ready, load_err, yy, mm, dd, wrap, at_end, seg7_sel, digit, dpt
  );
endinterface

// File: rtl/cal_seg7_scan.sv
// Six-digit display scanner: free-running prescaler, digit select walking
// 5 down to 0, BCD nibble mux and decimal points forming YY.MM.DD.
module cal_seg7_scan
  import cal_pkg::*;
#(
  parameter int SCAN_EXP = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] yy,
  input  logic [7:0] mm,
  input  logic [7:0] dd,
  output logic [2:0] seg7_sel,
  output logic [3:0] digit,
  output logic       dpt
);

  logic [SCAN_EXP-1:0] scan_cnt;

  // scan prescaler always runs; each terminal count moves one digit left
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      seg7_sel <= SEL_DD_ONES;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt)
        seg7_sel <= (seg7_sel == SEL_YY_TENS) ? SEL_DD_ONES : seg7_sel - 3'd1;
    end
  end

  // nibble and decimal point for the active digit
  always_comb begin
    digit = dd[3:0];
    case (seg7_sel)
      SEL_YY_TENS: digit = yy[7:4];
      SEL_YY_ONES: digit = yy[3:0];
      SEL_MM_TENS: digit = mm[7:4];
      SEL_MM_ONES: digit = mm[3:0];
      SEL_DD_TENS: digit = dd[7:4];
      default:     digit = dd[3:0];
    endcase
    dpt = (seg7_sel == SEL_MM_ONES) || (seg7_sel == SEL_YY_ONES);
  end

endmodule

// File: rtl/bcd_calendar_counter.sv
// YY.MM.DD BCD day counter with leap years, range wrap, validated load and
// display scanner. Macro CAL_DOWN_EN adds the down input and reverse stepping.
//
// state    | meaning
// ST_RUN   | counting, load_ready high, a load request is latched
// ST_CHECK | one cycle validating the latched date, no stepping
module bcd_calendar_counter
  import cal_pkg::*;
#(
  parameter int         TICK_EXP = 16,
  parameter int         SCAN_EXP = 15,
  parameter logic [7:0] YEAR_MIN = 8'h21,
  parameter logic [7:0] YEAR_MAX = 8'h48
) (
  input logic                   clk,
  input logic                   reset,
  bcd_calendar_counter_if.slave bus
);

  cal_state_t          state;
  logic [TICK_EXP-1:0] tick_cnt;
  logic [7:0]          yy_q, mm_q, dd_q;
  logic [7:0]          lyy, lmm, ldd;
  logic [7:0]          nyy, nmm, ndd;
  logic                nwrap;
  logic                ready_q, err_q, wrap_q;
  logic                dir_down, step, load_ok, end_up, end_down;

`ifdef CAL_DOWN_EN
  assign dir_down = bus.down;
`else
  assign dir_down = 1'b0;
`endif

  assign end_up   = (yy_q == YEAR_MAX) && (mm_q == MON_DEC) && (dd_q == 8'h31);
  assign end_down = (yy_q == YEAR_MIN) && (mm_q == MON_JAN) && (dd_q == 8'h01);
  // a step in the same cycle as a load acceptance is dropped
  assign step = (&tick_cnt) && bus.enable && (state == ST_RUN) && !bus.load_valid;

  // latched date check; raw compares are valid BCD order once nibbles are <= 9
  always_comb begin
    load_ok = (lyy[7:4] <= 4'h9) && (lyy[3:0] <= 4'h9) &&
              (lmm[7:4] <= 4'h9) && (lmm[3:0] <= 4'h9) &&
              (ldd[7:4] <= 4'h9) && (ldd[3:0] <= 4'h9) &&
              (lmm >= MON_JAN) && (lmm <= MON_DEC) &&
              (ldd >= 8'h01) && (ldd <= month_len(lyy, lmm)) &&
              (lyy >= YEAR_MIN) && (lyy <= YEAR_MAX);
  end

  // next date for one step in the current direction, digit-wise BCD
  always_comb begin
    nyy = yy_q; nmm = mm_q; ndd = dd_q; nwrap = 1'b0;
    if (dir_down) begin
      if (end_down) begin
        nyy = YEAR_MAX; nmm = MON_DEC; ndd = 8'h31; nwrap = 1'b1;
      end else if (dd_q == 8'h01) begin
        ndd = prev_month_len(yy_q, mm_q);
        if (mm_q == MON_JAN) begin
          nmm = MON_DEC; nyy = bcd_dec(yy_q);
        end else begin
          nmm = bcd_dec(mm_q);
        end
      end else begin
        ndd = bcd_dec(dd_q);
      end
    end else begin
      if (end_up) begin
        nyy = YEAR_MIN; nmm = MON_JAN; ndd = 8'h01; nwrap = 1'b1;
      end else if (dd_q == month_len(yy_q, mm_q)) begin
        ndd = 8'h01;
        if (mm_q == MON_DEC) begin
          nmm = MON_JAN; nyy = bcd_inc(yy_q);
        end else begin
          nmm = bcd_inc(mm_q);
        end
      end else begin
        ndd = bcd_inc(dd_q);
      end
    end
  end

  // day prescaler: holds while paused, restarts on an accepted load
  always_ff @(posedge clk) begin
    if (!reset)                            tick_cnt <= '0;
    else if (state == ST_CHECK && load_ok) tick_cnt <= '0;
    else if (bus.enable)                   tick_cnt <= tick_cnt + 1'b1;
  end

  // load FSM with date, wrap and handshake outputs registered alongside it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_RUN;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      yy_q    <= YEAR_MIN;
      mm_q    <= MON_JAN;
      dd_q    <= 8'h01;
      lyy     <= '0;
      lmm     <= '0;
      ldd     <= '0;
    end else begin
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.load_valid) begin
            lyy     <= bus.load_yy;
            lmm     <= bus.load_mm;
            ldd     <= bus.load_dd;
            state   <= ST_CHECK;
            ready_q <= 1'b0;
          end else if (step) begin
            yy_q   <= nyy;
            mm_q   <= nmm;
            dd_q   <= ndd;
            wrap_q <= nwrap;
          end
        end
        ST_CHECK: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
          if (load_ok) begin
            yy_q <= lyy;
            mm_q <= lmm;
            dd_q <= ldd;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.yy         = yy_q;
  assign bus.mm         = mm_q;
  assign bus.dd         = dd_q;
  assign bus.wrap       = wrap_q;
  assign bus.load_ready = ready_q;
  assign bus.load_err   = err_q;
`ifdef CAL_DOWN_EN
  assign bus.at_end = dir_down ? end_down : end_up;
`else
  assign bus.at_end = end_up;
`endif

  logic [2:0] scan_sel;
  logic [3:0] scan_digit;
  logic       scan_dpt;

  cal_seg7_scan #(.SCAN_EXP(SCAN_EXP)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .yy       (yy_q),
    .mm       (mm_q),
    .dd       (dd_q),
    .seg7_sel (scan_sel),
    .digit    (scan_digit),
    .dpt      (scan_dpt)
  );

  assign bus.seg7_sel = scan_sel;
  assign bus.digit    = scan_digit;
  assign bus.dpt      = scan_dpt;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Directed bench for bcd_calendar_counter with short prescalers
// (16 clocks per day step, 4 clocks per scan digit).
module tb_bcd_calendar_counter;
  import cal_pkg::*;

  localparam int TICK = 16;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bcd_calendar_counter_if bus ();

  bcd_calendar_counter #(
    .TICK_EXP (4),
    .SCAN_EXP (2),
    .YEAR_MIN (8'h21),
    .YEAR_MAX (8'h48)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_date(input string tag, input logic [23:0] exp);
    check(tag, {8'h0, bus.yy, bus.mm, bus.dd}, {8'h0, exp});
  endtask

  task automatic wait_steps(input int n);
    repeat (n * TICK) @(posedge clk);
    @(negedge clk);
  endtask

  // request at a negedge; returns at the negedge after the result edge
  task automatic load_date(input logic [23:0] d, input logic exp_err);
    bus.load_yy    = d[23:16];
    bus.load_mm    = d[15:8];
    bus.load_dd    = d[7:0];
    bus.load_valid = 1'b1;
    check("ready_run", bus.load_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.load_valid = 1'b0;
    check("ready_check", bus.load_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("load_err", bus.load_err, exp_err);
    check("ready_back", bus.load_ready, 1);
  endtask

  logic [23:0] bad_tab [4];
  logic [3:0]  exp_dig [6];
  logic [2:0]  prev;
  int          trans;

  initial begin
    total = 0;
    bad   = 0;
    bad_tab = '{24'h230229, 24'h190505, 24'h211301, 24'h211A01};
    exp_dig = '{4'h2, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1};
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_yy    = 8'h00;
    bus.load_mm    = 8'h00;
    bus.load_dd    = 8'h00;
`ifdef CAL_DOWN_EN
    bus.down = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // reset state
    check_date("rst_date", 24'h210101);
    check("rst_sel", bus.seg7_sel, 5);
    check("rst_digit", bus.digit, 1);
    check("rst_dpt", bus.dpt, 0);
    check("rst_ready", bus.load_ready, 1);
    check("rst_err", bus.load_err, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_at_end", bus.at_end, 0);

    // January then February of a non-leap year
    wait_steps(30);
    check_date("jan31", 24'h210131);
    wait_steps(1);
    check_date("feb01", 24'h210201);
    wait_steps(27);
    check_date("feb28", 24'h210228);
    wait_steps(1);
    check_date("mar01", 24'h210301);

    // leap February
    load_date(24'h240228, 1'b0);
    check_date("load_240228", 24'h240228);
    wait_steps(1);
    check_date("leap_feb29", 24'h240229);
    wait_steps(1);
    check_date("leap_mar01", 24'h240301);

    // range end and wrap
    load_date(24'h481231, 1'b0);
    check_date("load_481231", 24'h481231);
    check("at_end_max", bus.at_end, 1);
    repeat (TICK - 1) @(posedge clk);
    @(negedge clk);
    check_date("pre_wrap", 24'h481231);
    check("pre_wrap_pulse", bus.wrap, 0);
    @(posedge clk);
    @(negedge clk);
    check_date("wrapped", 24'h210101);
    check("wrap_pulse", bus.wrap, 1);
    check("at_end_after", bus.at_end, 0);
    @(posedge clk);
    @(negedge clk);
    check("wrap_one_cycle", bus.wrap, 0);

    // rejected loads with the counter paused
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_date(bad_tab[i], 1'b1);
      check_date("bad_load_keep", 24'h210101);
      @(posedge clk);
      @(negedge clk);
      check("err_one_cycle", bus.load_err, 0);
    end

    // paused for three tick periods: date frozen, scanner still walks
    prev  = bus.seg7_sel;
    trans = 0;
    for (int i = 0; i < 3 * TICK; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.seg7_sel != prev) begin
        trans++;
        check("sel_order", bus.seg7_sel, (prev == 3'd0) ? 3'd5 : prev - 3'd1);
        prev = bus.seg7_sel;
      end
      check("dpt", bus.dpt, (bus.seg7_sel == 3'd3) || (bus.seg7_sel == 3'd1));
      check("digit", bus.digit, exp_dig[bus.seg7_sel]);
    end
    check("scan_advances", trans, 12);
    check_date("frozen", 24'h210101);
    bus.enable = 1'b1;

`ifdef CAL_DOWN_EN
    // reverse stepping across a leap February and the range start
    bus.down = 1'b1;
    load_date(24'h240301, 1'b0);
    wait_steps(1);
    check_date("down_feb29", 24'h240229);
    load_date(24'h210101, 1'b0);
    check("at_end_min", bus.at_end, 1);
    wait_steps(1);
    check_date("down_wrap_date", 24'h481231);
    check("down_wrap_pulse", bus.wrap, 1);
    @(posedge clk);
    @(negedge clk);
    check("down_wrap_one", bus.wrap, 0);
    bus.down = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_calendar_counter.md
# bcd_calendar_counter

Parametrised BCD calendar counter for the lab seven-segment board: counts YY.MM.DD days with correct month lengths and leap years over a configurable two-digit year range, pausable, with a validated date-load handshake and a built-in six-digit display scanner. The counter and scanner run from one clock using clock enables rather than derived clocks. The `digit` output feeds the existing `bcd_to_seg7` decoder. `seg7_sel` and `dpt` drive the board directly.

## Interface
- `TICK_EXP`, 16, day-step prescaler width; one step per 2^TICK_EXP clocks
- `SCAN_EXP`, 15, scan prescaler width; one digit advance per 2^SCAN_EXP clocks
- `YEAR_MIN`, 8'h21, first year (BCD, 00–99, meaning 2000–2099)
- `YEAR_MAX`, 8'h48, last year (BCD, ≥ YEAR_MIN)
- `clk` in 1, system clock
- `reset` in 1, synchronous, active-low
- `enable` in 1, 1 = count, 0 = pause (prescaler holds)
- `down` in 1, 1 = count backwards (present only with `CAL_DOWN_EN`)
- `load_valid` in 1, load request
- `load_ready` out 1, load may be accepted
- `load_yy`, `load_mm`, `load_dd` in 8 each, BCD date to load
- `load_err` out 1, one-cycle pulse: rejected load
- `yy`, `mm`, `dd` out 8 each, current date, BCD
- `wrap` out 1, one-cycle pulse when the range wraps
- `at_end` out 1, level: date equals YEAR_MAX.12.31 (up) / YEAR_MIN.01.01 (down)
- `seg7_sel` out 3, active digit 5 (rightmost) … 0
- `digit` out 4, BCD nibble for the active digit
- `dpt` out 1, decimal point for the active digit

## Operation
- Leap year: yy%4==0. In BCD: tens even and ones ∈{0,4,8}, or tens odd and ones ∈{2,6}. Feb = 29/28; Apr/Jun/Sep/Nov = 30; others = 31.
- Step = prescaler terminal count AND `enable` AND state RUN.
- Up step:
  - dd+1.
  - If dd = month length: dd→01, mm+1.
  - If mm = 12 too: mm→01, yy+1.
  - At YEAR_MAX.12.31: go to YEAR_MIN.01.01 and pulse `wrap`.
- Down step is the mirror:
  - At dd = 01: dd→month length of the previous month (leap-correct), decrement mm.
  - At YEAR_MIN.01.01: go to YEAR_MAX.12.31 and pulse `wrap`.
- BCD digit rollover: ones 9→0 carries to tens; down 0→9 borrows. No binary intermediate.
- Load FSM, states RUN and CHECK:
  - RUN: `load_ready`=1. `load_valid`&&`load_ready` latches the inputs and goes to CHECK.
  - CHECK (1 cycle): `load_ready`=0, no stepping.
  - Valid load: date ← loaded value, prescaler ← 0, back to RUN.
  - Invalid load: date unchanged, `load_err`=1 for that cycle, back to RUN.
  - Validity: every nibble ≤ 9; mm in 01–12; dd in 01–month length for (load_yy, load_mm); YEAR_MIN ≤ load_yy ≤ YEAR_MAX.
- Display mapping:
  - 5/4 = dd ones/tens; 3/2 = mm ones/tens; 1/0 = yy ones/tens.
  - `dpt`=1 only when `seg7_sel` is 3 or 1, giving YY.MM.DD.
  - `seg7_sel` decrements 5→0, then wraps to 5.

## Timing
- Reset (reset=0 at a clk edge) sets:
  - date = YEAR_MIN.01.01, both prescalers 0, state RUN.
  - `seg7_sel`=5, `digit`=1, `dpt`=0.
  - `load_ready`=1, `load_err`=0, `wrap`=0.
  - `at_end`=0 in up mode, or 1 in down mode (reset date equals the down end).
- Reset mid-CHECK abandons the load, with no `load_err`.
- Date registers update on the clk edge after the step condition. `wrap` is registered with the date: high for exactly the cycle the wrapped date first appears.
- `at_end`, `digit` and `dpt` are combinational from registers.
- A step coinciding with load acceptance, or occurring in CHECK, is dropped. The load wins.
- `enable`=0 freezes the day prescaler. The scan prescaler always runs.
- Changing `down` between steps takes effect on the next step. No glitch.
- Load result is visible 2 clocks after acceptance.

## Configuration
- `CAL_DOWN_EN`
  - Defined: `down` port and down-step logic exist; `at_end` is direction-dependent.
  - Undefined: up-count only; `down` port absent; `at_end` means YEAR_MAX.12.31.

## Structure
- Package `cal_pkg`:
  - BCD month constants.
  - `is_leap(yy)` and `month_len(yy,mm)` returning 8-bit BCD.
  - `prev_month_len`.
  - `seg7_sel` digit-index constants.
  - FSM state enum.
- Sub-module `cal_seg7_scan`: scan prescaler, `seg7_sel` counter, digit mux, `dpt`.

## Test plan
- Reset, enable=1, run 31 steps from 21.01.01 -> 21.02.01. Then 28 more steps -> 21.03.01, with no 21.02.29.
- Load 24.02.28, one step -> 24.02.29. Next step -> 24.03.01.
- Load 48.12.31 -> `at_end`=1. One step -> 21.01.01, `wrap` high for exactly one cycle.
- Invalid loads (23.02.29, 19.05.05, 21.13.01, 21.1A.01) -> `load_err` pulse, date unchanged. Each is accepted in RUN, then `load_ready` low for 1 cycle.
- enable=0 for 3 tick periods -> date frozen, `seg7_sel` still cycles 5..0. `dpt`=1 only at sel 3 and 1.
- `CAL_DOWN_EN`, down=1, from 24.03.01 -> 24.02.29. From 21.01.01 -> 48.12.31 with `wrap`.
